// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I-subset encodings, ALU operation type and execute helpers.
// Revision: 1.0
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  // The alternate funct7 selects SUB only for register-register ops; for ADDI bit 30 is immediate.
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input alu_op_e op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << b[4:0];
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  res = a ^ b;
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = $signed(a) >>> b[4:0];
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      default:  res = '0;
    endcase
    return res;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic t;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_soc_if.sv
// riscv_soc_if: instruction fetch bus between the core (master) and the ROM (slave).
// Revision: 1.0
`default_nettype none

interface riscv_soc_if #(
  parameter int IDX_W = 12
);
  logic [IDX_W-1:0] idx;
  logic [31:0]      instr;

  modport master (output idx, input instr);
  modport slave  (input idx, output instr);
endinterface

`default_nettype wire

// File: rtl/regs.sv
// regs: 32x32 register file, two combinational read ports and one write port; x0 is hardwired 0.
// Revision: 1.0
`default_nettype none

module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : regs[i_raddr2];
endmodule

`default_nettype wire

// File: rtl/riscv.sv
// riscv: single-cycle RV32I-subset core; decode, ALU and next-PC are combinational from the fetched word.
// Revision: 1.0
`default_nettype none

module riscv
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_W    = 12
) (
  input  logic         clk,
  input  logic         rst,
  riscv_soc_if.master  imem
);
  logic [31:0] r_pc;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic [31:0] w_wdata;
  logic        w_we;

  // pc[1:0] never reaches the ROM, so misaligned targets fetch the enclosing word.
  assign imem.idx = r_pc[IDX_W+1:2];
  assign w_instr  = imem.instr;

  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_alt    = (w_instr[31:25] == F7_ALT);

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_pc_plus4 = r_pc + 32'd4;

  regs regs_inst (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wdata)
  );

  always_comb begin
    w_we      = 1'b0;
    w_wdata   = '0;
    w_next_pc = w_pc_plus4;
    case (w_opcode)
      OP_LUI: begin
        w_we    = 1'b1;
        w_wdata = w_imm_u;
      end
      OP_AUIPC: begin
        w_we    = 1'b1;
        w_wdata = r_pc + w_imm_u;
      end
      OP_JAL: begin
        w_we      = 1'b1;
        w_wdata   = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        w_we      = 1'b1;
        w_wdata   = w_pc_plus4;
        w_next_pc = (w_rs1_data + w_imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (br_taken(w_funct3, w_rs1_data, w_rs2_data)) begin
          w_next_pc = r_pc + w_imm_b;
        end
      end
      OP_IMM: begin
        w_we    = 1'b1;
        w_wdata = alu_exec(alu_sel(w_funct3, w_alt, 1'b0), w_rs1_data, w_imm_i);
      end
      OP_OP: begin
        w_we    = 1'b1;
        w_wdata = alu_exec(alu_sel(w_funct3, w_alt, 1'b1), w_rs1_data, w_rs2_data);
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end
endmodule

`default_nettype wire

// File: rtl/rom.sv
// rom: instruction memory with combinational word read; contents are preloaded externally.
// Revision: 1.0
`default_nettype none

module rom #(
  parameter int ROM_DEPTH = 4096
) (
  riscv_soc_if.slave bus
);
  logic [31:0] rom_mem [0:ROM_DEPTH-1];

  assign bus.instr = rom_mem[bus.idx];
endmodule

`default_nettype wire

// File: rtl/riscv_soc.sv
// riscv_soc: top level tying the single-cycle core to its instruction ROM over the fetch interface.
// Revision: 1.0
`default_nettype none

module riscv_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int IDX_W = $clog2(ROM_DEPTH);

  riscv_soc_if #(.IDX_W(IDX_W)) imem ();

  rom #(
    .ROM_DEPTH (ROM_DEPTH)
  ) rom_inst (
    .bus (imem)
  );

  riscv #(
    .RESET_PC (RESET_PC),
    .IDX_W    (IDX_W)
  ) riscv_inst (
    .clk  (clk),
    .rst  (rst),
    .imem (imem)
  );
endmodule

`default_nettype wire

// File: tb/tb_riscv_soc.sv
// tb_riscv_soc: directed program run with hand-computed register results, reset and mid-loop reset checks.
// Revision: 1.0
`default_nettype none

module tb_riscv_soc;
  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog     [0:31];
  logic [31:0] exp_regs [0:31];

  riscv_soc #(
    .ROM_DEPTH (4096),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] xreg(input int i);
    return dut.riscv_inst.regs_inst.regs[i];
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic wait_pc(input logic [31:0] target, input int max_cyc, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (dut.riscv_inst.r_pc == target) begin
        hit = 1'b1;
        break;
      end
    end
    check(tag, {31'b0, hit}, 32'd1);
  endtask

  task automatic check_all_regs(input string run);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_x%0d", run, i), xreg(i), exp_regs[i]);
    end
  endtask

  initial begin
    logic hit;
    rst = 1'b1;

    prog[0]  = enc_i(7'b0010011, 5'd27, 3'b000, 5'd0,  12'd5);         // 0x00 addi x27,x0,5
    prog[1]  = enc_i(7'b0010011, 5'd28, 3'b000, 5'd0,  12'hFFD);       // 0x04 addi x28,x0,-3
    prog[2]  = enc_r(7'b0000000, 5'd28, 5'd27, 3'b000, 5'd29);         // 0x08 add x29,x27,x28
    prog[3]  = enc_i(7'b0010011, 5'd1,  3'b000, 5'd0,  12'd0);         // 0x0C addi x1,x0,0
    prog[4]  = enc_i(7'b0010011, 5'd2,  3'b000, 5'd0,  12'd10);        // 0x10 addi x2,x0,10
    prog[5]  = enc_i(7'b0010011, 5'd1,  3'b000, 5'd1,  12'd1);         // 0x14 addi x1,x1,1
    prog[6]  = enc_b(3'b001, 5'd1, 5'd2, 13'h1FFC);                    // 0x18 bne x1,x2,-4
    prog[7]  = enc_i(7'b0010011, 5'd0,  3'b000, 5'd0,  12'd7);         // 0x1C addi x0,x0,7
    prog[8]  = enc_j(5'd3, 21'd8);                                     // 0x20 jal x3,+8
    prog[9]  = enc_i(7'b0010011, 5'd4,  3'b000, 5'd0,  12'd1);         // 0x24 skipped
    prog[10] = enc_u(7'b0110111, 5'd5, 20'h80000);                     // 0x28 lui x5,0x80000
    prog[11] = enc_i(7'b0010011, 5'd6,  3'b000, 5'd0,  12'd1);         // 0x2C addi x6,x0,1
    prog[12] = enc_r(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd7);            // 0x30 sub x7,x5,x6
    prog[13] = enc_r(7'b0000000, 5'd6, 5'd5, 3'b010, 5'd8);            // 0x34 slt x8,x5,x6
    prog[14] = enc_r(7'b0000000, 5'd6, 5'd5, 3'b011, 5'd9);            // 0x38 sltu x9,x5,x6
    prog[15] = enc_i(7'b0010011, 5'd10, 3'b101, 5'd5,  12'h404);       // 0x3C srai x10,x5,4
    prog[16] = enc_i(7'b0010011, 5'd11, 3'b101, 5'd5,  12'h004);       // 0x40 srli x11,x5,4
    prog[17] = enc_u(7'b0010111, 5'd12, 20'h00001);                    // 0x44 auipc x12,1
    prog[18] = enc_i(7'b1100111, 5'd13, 3'b000, 5'd0,  12'h055);       // 0x48 jalr x13,0x55(x0)
    prog[19] = enc_i(7'b0010011, 5'd14, 3'b000, 5'd0,  12'd1);         // 0x4C skipped
    prog[20] = enc_i(7'b0010011, 5'd14, 3'b000, 5'd0,  12'd2);         // 0x50 skipped
    prog[21] = enc_i(7'b0010011, 5'd15, 3'b100, 5'd5,  12'hFFF);       // 0x54 xori x15,x5,-1
    prog[22] = enc_b(3'b100, 5'd5, 5'd6, 13'd8);                       // 0x58 blt x5,x6,+8 (taken)
    prog[23] = enc_i(7'b0010011, 5'd16, 3'b000, 5'd0,  12'd1);         // 0x5C skipped
    prog[24] = enc_b(3'b110, 5'd5, 5'd6, 13'd8);                       // 0x60 bltu x5,x6,+8 (not taken)
    prog[25] = enc_i(7'b0010011, 5'd17, 3'b000, 5'd0,  12'd9);         // 0x64 addi x17,x0,9
    prog[26] = enc_i(7'b0010011, 5'd19, 3'b000, 5'd0,  12'd33);        // 0x68 addi x19,x0,33
    prog[27] = enc_r(7'b0000000, 5'd19, 5'd6, 3'b001, 5'd18);          // 0x6C sll x18,x6,x19
    for (int i = 28; i < 32; i++) prog[i] = 32'h0000_0000;

    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) dut.rom_inst.rom_mem[i] = prog[i];

    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    exp_regs[1]  = 32'd10;
    exp_regs[2]  = 32'd10;
    exp_regs[3]  = 32'h0000_0024;
    exp_regs[5]  = 32'h8000_0000;
    exp_regs[6]  = 32'd1;
    exp_regs[7]  = 32'h7FFF_FFFF;
    exp_regs[8]  = 32'd1;
    exp_regs[9]  = 32'd0;
    exp_regs[10] = 32'hF800_0000;
    exp_regs[11] = 32'h0800_0000;
    exp_regs[12] = 32'h0000_1044;
    exp_regs[13] = 32'h0000_004C;
    exp_regs[15] = 32'h7FFF_FFFF;
    exp_regs[17] = 32'd9;
    exp_regs[18] = 32'd2;
    exp_regs[19] = 32'd33;
    exp_regs[27] = 32'd5;
    exp_regs[28] = 32'hFFFF_FFFD;
    exp_regs[29] = 32'd2;

    #2 rst = 1'b0;
    #23;
    check("reset_pc", dut.riscv_inst.r_pc, 32'h0);
    check("reset_x1", xreg(1), 32'h0);
    check("reset_x31", xreg(31), 32'h0);
    #10 rst = 1'b1;

    @(negedge clk);
    check("pc_step0", dut.riscv_inst.r_pc, 32'h0);
    @(negedge clk);
    check("pc_step4", dut.riscv_inst.r_pc, 32'h4);
    @(negedge clk);
    check("pc_step8", dut.riscv_inst.r_pc, 32'h8);

    wait_pc(32'h70, 200, "run1_reach_end");
    check_all_regs("run1");

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.riscv_inst.r_pc == 32'h18 && xreg(1) == 32'd3) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_mid_loop", {31'b0, hit}, 32'd1);
    check("mid_x27_before", xreg(27), 32'd5);

    #5 rst = 1'b0;
    #1;
    check("midrst_pc", dut.riscv_inst.r_pc, 32'h0);
    check("midrst_x1", xreg(1), 32'h0);
    check("midrst_x27", xreg(27), 32'h0);
    check("midrst_x29", xreg(29), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    wait_pc(32'h70, 200, "run2_reach_end");
    check_all_regs("run2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
